kcounter_ctrl: RTL

Sequencer for the ADPLL digital loop filter's K-counter: converts phase-detector up/down pulses into count instructions for an external `UpDownCounter`, and watches the returned count against a programmable modulus K. When the count reaches ±K it emits a one-cycle carry/borrow pulse to the DCO increment/decrement logic, then clears and re-arms the counter. An optional lock detector flags loop lock when no carry/borrow occurs for a configurable window.

---
 rtl/kcounter_ctrl.sv | 75 +++++++
 1 files changed

// File: rtl/kcounter_ctrl.sv
// kcounter_ctrl: ADPLL K-counter sequencer issuing count instructions and carry/borrow pulses.
// Optional lock detector built when KCOUNTER_LOCK_DETECT_EN is defined; otherwise locked_o is 0.
module kcounter_ctrl #(
  parameter int WIDTH = 5,
  parameter int LOCK_WINDOW = 64
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    pd_up_i,
  input  logic                    pd_dn_i,
  input  logic [WIDTH-2:0]        threshold_i,
  input  logic signed [WIDTH-1:0] counter_val_i,
  output logic [1:0]              count_instr_o,
  output logic                    clear_o,
  output logic                    carry_o,
  output logic                    borrow_o,
  output logic                    locked_o
);
  typedef enum logic [1:0] {IDLE, COUNT, CLEAR, SETTLE} state_t;
  // Clamp keeps the one in-flight step after detection from wrapping the counter
  localparam logic signed [WIDTH-1:0] KMAX = WIDTH'(2**(WIDTH-1)-2);
  state_t state, state_n;
  logic signed [WIDTH-1:0] k, kn;
  logic up, dn, clear_n;
  logic [1:0] instr_n;
  always_comb begin
    k = ({1'b0, threshold_i} > KMAX) ? KMAX : {1'b0, threshold_i};
    kn = -k;
    up = enable_i && state == COUNT && k != '0 && counter_val_i >= k;
    dn = enable_i && state == COUNT && k != '0 && counter_val_i <= kn;
    state_n = !enable_i ? IDLE :
              state == IDLE ? COUNT :
              state == COUNT ? ((up || dn) ? CLEAR : COUNT) :
              state == CLEAR ? SETTLE : COUNT;
    instr_n = state_n != COUNT ? 2'b00 :
              (pd_up_i && !pd_dn_i) ? 2'b01 :
              (pd_dn_i && !pd_up_i) ? 2'b10 : 2'b00;
    clear_n = state_n == IDLE || state_n == CLEAR;
  end
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      count_instr_o <= 2'b00;
      clear_o <= 1'b1;
      carry_o <= 1'b0;
      borrow_o <= 1'b0;
    end else begin
      state <= state_n;
      count_instr_o <= instr_n;
      clear_o <= clear_n;
      carry_o <= up;
      borrow_o <= dn;
    end
  end
`ifdef KCOUNTER_LOCK_DETECT_EN
  localparam int LW = $clog2(LOCK_WINDOW + 1);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_WINDOW);
  logic [LW-1:0] lock_cnt, lock_n;
  always_comb
    lock_n = (state_n == IDLE || up || dn) ? '0 :
             (state == COUNT && lock_cnt != LMAX) ? lock_cnt + LW'(1) : lock_cnt;
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      lock_cnt <= '0;
      locked_o <= 1'b0;
    end else begin
      lock_cnt <= lock_n;
      locked_o <= lock_n == LMAX;
    end
  end
`else
  assign locked_o = 1'b0;
`endif
endmodule
